// File: rtl/prover_interpolate_qc.sv
// Sum-check round helper: turns evaluations at x = 0, 1, -1, 2 into the
// monomial coefficients of a quadratic or cubic over the prime field.
`ifndef F_NBITS
`define F_NBITS 64
`endif
`ifndef F_PRIME
`define F_PRIME 64'hFFFF_FFFF_0000_0001
`endif
`ifndef F_M1
`define F_M1 (`F_PRIME - 1)
`endif

module prover_interpolate_qc (
    input  logic                clk,
    input  logic                rstb,
    input  logic                en,
    input  logic                cubic,
    input  logic [`F_NBITS-1:0] y_in  [3:0],
    output logic [`F_NBITS-1:0] c_out [3:0],
    output logic                ready_pulse,
    output logic                ready
);

    localparam int unsigned W = `F_NBITS;
    typedef logic [W-1:0] fe_t;
    localparam fe_t P = `F_PRIME;

    // 6^-1 is (k*p + 1)/6 for the unique k in 1..5 making that exact
    function automatic fe_t inv6_of(input fe_t p);
        logic [W+2:0] t;
        inv6_of = '0;
        for (int unsigned k = 1; k < 6; k++) begin
            t = {3'b000, p} * (W+3)'(k) + (W+3)'(1);
            if (t % (W+3)'(6) == '0)
                inv6_of = fe_t'(t / (W+3)'(6));
        end
    endfunction

    localparam logic [W:0] P_PLUS1 = {1'b0, P} + 1'b1;
    localparam fe_t INV2 = P_PLUS1[W:1];
    localparam fe_t INV6 = inv6_of(P);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SUMS  = 3'd1;
    localparam logic [2:0] HALF  = 3'd2;
    localparam logic [2:0] C3    = 3'd3;
    localparam logic [2:0] FINAL = 3'd4;

    function automatic fe_t fadd(input fe_t a, input fe_t b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, P})
            s = s - {1'b0, P};
        return fe_t'(s);
    endfunction

    // a < b case wraps through W bits, landing on a - b + p
    function automatic fe_t fsub(input fe_t a, input fe_t b);
        return (a >= b) ? (a - b) : (a - b + P);
    endfunction

    function automatic fe_t fmul(input fe_t a, input fe_t b);
        logic [2*W-1:0] prod;
        prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        return fe_t'(prod % {{W{1'b0}}, P});
    endfunction

    logic [2:0] state;
    fe_t        yr [3:0];
    logic       cub_r;
    fe_t        s_r, d_r, c2_r, o_r, c3_r;
    fe_t        c2x4, resid;

    always_comb begin
        c2x4  = fadd(fadd(c2_r, c2_r), fadd(c2_r, c2_r));
        resid = fsub(fsub(fsub(yr[3], yr[0]), c2x4), fadd(o_r, o_r));
    end

    assign ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state       <= IDLE;
            ready_pulse <= 1'b0;
            for (int unsigned i = 0; i < 4; i++)
                c_out[i] <= '0;
        end else begin
            ready_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (en) begin
                        yr    <= y_in;
                        cub_r <= cubic;
                        state <= SUMS;
                    end
                end
                SUMS: begin
                    s_r   <= fadd(yr[1], yr[2]);
                    d_r   <= fsub(yr[1], yr[2]);
                    state <= HALF;
                end
                HALF: begin
                    c2_r  <= fsub(fmul(s_r, INV2), yr[0]);
                    o_r   <= fmul(d_r, INV2);
                    c3_r  <= '0;
                    state <= cub_r ? C3 : FINAL;
                end
                C3: begin
                    c3_r  <= fmul(resid, INV6);
                    state <= FINAL;
                end
                FINAL: begin
                    // c3 is zero for quadratics, so c1 = o falls out of the same path
                    c_out[0]    <= yr[0];
                    c_out[1]    <= fsub(o_r, c3_r);
                    c_out[2]    <= c2_r;
                    c_out[3]    <= c3_r;
                    ready_pulse <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prover_interpolate_qc.sv
// Scoreboard bench for prover_interpolate_qc: expected coefficients come
// from Lagrange interpolation with generic modular inverses.
`timescale 1ns/1ps
`ifndef F_NBITS
`define F_NBITS 64
`endif
`ifndef F_PRIME
`define F_PRIME 64'hFFFF_FFFF_0000_0001
`endif
`ifndef F_M1
`define F_M1 (`F_PRIME - 1)
`endif

module tb_prover_interpolate_qc;

    localparam int W = `F_NBITS;
    typedef logic [W-1:0] fe_t;
    typedef logic [3:0][W-1:0] vec_t;
    localparam fe_t P  = `F_PRIME;
    localparam fe_t M1 = `F_M1;

    typedef struct {
        bit   cub;
        vec_t y;
        vec_t c;
    } item_t;

    logic clk = 1'b0;
    logic rstb = 1'b0;
    logic en = 1'b0;
    logic cubic = 1'b0;
    fe_t  y_in  [3:0];
    fe_t  c_out [3:0];
    logic ready_pulse, ready;

    item_t sb[$];
    int errors = 0;
    int checks = 0;
    int pulses = 0;
    logic prev_pulse = 1'b0;

    prover_interpolate_qc dut (
        .clk(clk), .rstb(rstb), .en(en), .cubic(cubic),
        .y_in(y_in), .c_out(c_out), .ready_pulse(ready_pulse), .ready(ready)
    );

    always #5 clk = ~clk;

    // ---------------- field helpers (128-bit plain arithmetic) ----------------
    function automatic fe_t addm(input fe_t a, input fe_t b);
        logic [127:0] t;
        t = 128'(a) + 128'(b);
        return fe_t'(t % 128'(P));
    endfunction

    function automatic fe_t subm(input fe_t a, input fe_t b);
        logic [127:0] t;
        t = 128'(a) + 128'(P) - 128'(b);
        return fe_t'(t % 128'(P));
    endfunction

    function automatic fe_t mulm(input fe_t a, input fe_t b);
        logic [127:0] t;
        t = 128'(a) * 128'(b);
        return fe_t'(t % 128'(P));
    endfunction

    function automatic fe_t invm(input fe_t a);
        fe_t r, b, e;
        r = 1; b = a; e = P - 2;
        for (int i = 0; i < W; i++) begin
            if (e[i]) r = mulm(r, b);
            b = mulm(b, b);
        end
        return r;
    endfunction

    function automatic fe_t rand_fe();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return fe_t'(r % 128'(P));
    endfunction

    function automatic vec_t mk(input fe_t a, input fe_t b, input fe_t c, input fe_t d);
        vec_t v;
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        return v;
    endfunction

    // Sum of y_i * L_i(x) over the active nodes, expanded to monomials
    function automatic vec_t ref_coeffs(input bit cub, input vec_t y);
        fe_t xs [4];
        fe_t poly [4];
        fe_t nxt [4];
        fe_t den, sc;
        vec_t c;
        int n;
        xs = '{0, 1, M1, 2};
        n = cub ? 4 : 3;
        c = '0;
        for (int i = 0; i < n; i++) begin
            poly = '{1, 0, 0, 0};
            den = 1;
            for (int j = 0; j < n; j++) begin
                if (j != i) begin
                    nxt[0] = subm(0, mulm(xs[j], poly[0]));
                    for (int k = 1; k < 4; k++)
                        nxt[k] = subm(poly[k-1], mulm(xs[j], poly[k]));
                    poly = nxt;
                    den = mulm(den, subm(xs[i], xs[j]));
                end
            end
            sc = mulm(y[i], invm(den));
            for (int k = 0; k < 4; k++)
                c[k] = addm(c[k], mulm(sc, poly[k]));
        end
        return c;
    endfunction

    function automatic fe_t horner(input vec_t c, input fe_t x);
        fe_t r;
        r = c[3];
        for (int k = 2; k >= 0; k--)
            r = addm(mulm(r, x), c[k]);
        return r;
    endfunction

    task automatic check(input string name, input fe_t act, input fe_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    item_t it;
    vec_t  cv;
    always @(negedge clk) begin
        if (rstb && ready_pulse) begin
            pulses++;
            check("ready_with_pulse", ready, 1);
            check("pulse_width", prev_pulse, 0);
            for (int i = 0; i < 4; i++) cv[i] = c_out[i];
            if (sb.size() == 0) begin
                check("unexpected_pulse", ready_pulse, 0);
            end else begin
                it = sb.pop_front();
                for (int i = 0; i < 4; i++)
                    check($sformatf("c%0d", i), cv[i], it.c[i]);
                check("eval_0",  horner(cv, 0),  it.y[0]);
                check("eval_1",  horner(cv, 1),  it.y[1]);
                check("eval_m1", horner(cv, M1), it.y[2]);
                if (it.cub) check("eval_2", horner(cv, 2), it.y[3]);
                else        check("quad_c3_zero", cv[3], 0);
            end
        end
        prev_pulse = rstb && ready_pulse;
    end

    // ---------------- driver ----------------
    task automatic issue(input bit cub, input vec_t y, input vec_t c);
        item_t e;
        en = 1'b1;
        cubic = cub;
        for (int i = 0; i < 4; i++) y_in[i] = y[i];
        e.cub = cub; e.y = y; e.c = c;
        sb.push_back(e);
    endtask

    task automatic scramble();
        for (int i = 0; i < 4; i++) y_in[i] = rand_fe();
        cubic = $urandom_range(0, 1);
    endtask

    // Call at posedge+1 right after the start edge; counts cycles to ready_pulse
    task automatic wait_done(output int lat);
        lat = 0;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            check("ready_tracks_busy", ready, ready_pulse);
            if (ready_pulse) break;
        end
        check("done_in_time", ready_pulse, 1);
    endtask

    task automatic wait_ready();
        for (int k = 0; k < 40 && !ready; k++) @(negedge clk);
        check("ready_before_start", ready, 1);
    endtask

    task automatic run_one(input bit cub, input vec_t y, input vec_t c, output int lat);
        @(negedge clk);
        wait_ready();
        issue(cub, y, c);
        @(posedge clk); #1;
        en = 1'b0;
        scramble();
        check("ready_drop", ready, 0);
        wait_done(lat);
        @(negedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t y;
        int lat, lat_q, lat_c, p0;
        bit cub;
        for (int i = 0; i < 4; i++) y_in[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) check("reset_c_out", c_out[i], 0);
        check("reset_ready", ready, 1);
        check("reset_pulse", ready_pulse, 0);
        @(negedge clk) rstb = 1'b1;

        run_one(0, mk(5, 6, 6, rand_fe()), mk(5, 0, 1, 0), lat_q);
        run_one(1, mk(0, 1, M1, 8), mk(0, 0, 0, 1), lat_c);
        run_one(0, mk(0, 1, M1, rand_fe()), mk(0, 1, 0, 0), lat);
        check("lat_quad_const", lat, lat_q);
        run_one(1, mk(7, 7, 7, 7), mk(7, 0, 0, 0), lat);
        check("lat_cubic_const", lat, lat_c);
        check("lat_quad_range", (lat_q >= 2 && lat_q <= 32), 1);
        check("lat_cubic_range", (lat_c >= 2 && lat_c <= 32), 1);
        check("lat_order", (lat_c >= lat_q), 1);

        // back-to-back, next start issued in the ready_pulse cycle
        @(negedge clk);
        wait_ready();
        cub = 0;
        y = mk(rand_fe(), rand_fe(), rand_fe(), rand_fe());
        issue(cub, y, ref_coeffs(cub, y));
        for (int r = 0; r < 100; r++) begin
            @(posedge clk); #1;
            en = 1'b0;
            scramble();
            wait_done(lat);
            check("lat_b2b", lat, cub ? lat_c : lat_q);
            if (lat >= 40) break;
            if (r < 99) begin
                cub = ~cub;
                y = mk(rand_fe(), rand_fe(), rand_fe(), rand_fe());
                issue(cub, y, ref_coeffs(cub, y));
            end
        end
        repeat (3) @(negedge clk);
        #1;
        check("b2b_drained", sb.size(), 0);

        // en while busy plus input changes after capture
        wait_ready();
        y = mk(rand_fe(), rand_fe(), rand_fe(), rand_fe());
        p0 = pulses;
        issue(0, y, ref_coeffs(0, y));
        @(posedge clk); #1;
        en = 1'b0;
        @(negedge clk);
        en = 1'b1;
        scramble();
        @(posedge clk); #1;
        en = 1'b0;
        scramble();
        for (int k = 0; k < 40 && pulses == p0; k++) @(negedge clk);
        repeat (8) @(negedge clk);
        #1;
        check("single_pulse", pulses - p0, 1);

        // reset mid-computation
        wait_ready();
        y = mk(rand_fe(), rand_fe(), rand_fe(), rand_fe());
        issue(1, y, ref_coeffs(1, y));
        @(posedge clk); #1;
        en = 1'b0;
        @(negedge clk);
        rstb = 1'b0;
        @(posedge clk); #1;
        sb.delete();
        for (int i = 0; i < 4; i++) check("abort_c_out", c_out[i], 0);
        check("abort_ready", ready, 1);
        check("abort_pulse", ready_pulse, 0);
        @(negedge clk);
        rstb = 1'b1;
        p0 = pulses;
        repeat (10) @(negedge clk);
        #1;
        check("abort_no_pulse", pulses - p0, 0);

        y = mk(rand_fe(), rand_fe(), rand_fe(), rand_fe());
        run_one(1, y, ref_coeffs(1, y), lat);
        check("lat_after_reset", lat, lat_c);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
